// File: rtl/sram_like_responder.sv
// SRAM-like data-bus responder: word-addressed memory behind a fixed-latency,
// in-order response queue. Every accepted request gets exactly one data_ok pulse.
module sram_like_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PtrW  = $clog2(QDEPTH);
  localparam int unsigned Words = 2 ** ADDR_W;
  localparam logic [3:0]      CntInit = 4'(LATENCY - 1);
  localparam logic [PtrW:0]   QFull   = (PtrW + 1)'(QDEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  logic [31:0]       mem_q [Words];
  logic [ADDR_W-1:0] word_idx;

  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]     count_q;
  logic [QDEPTH-1:0] is_wr_q;
  logic [31:0]       data_q [QDEPTH];
  logic [3:0]        cnt_q  [QDEPTH];
  logic [QDEPTH-1:0] valid;
  logic              push, pop;

  // Size and the aliased address bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  // Handshake and response decode; everything is forced quiet while reset is high.
  always_comb begin
    word_idx = addr[ADDR_W+1:2];
    addr_ok  = ~reset & ~stall_en & (count_q != QFull);
    data_ok  = ~reset & (count_q != '0) & (cnt_q[rd_ptr_q] == 4'd0);
    rdata    = (data_ok & ~is_wr_q[rd_ptr_q]) ? data_q[rd_ptr_q] : 32'd0;
    push     = req & addr_ok;
    pop      = data_ok;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      valid[i] = ({1'b0, PtrW'(i) - rd_ptr_q}) < count_q;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push && !pop)      count_q <= count_q + CntOne;
      else if (!push && pop) count_q <= count_q - CntOne;
    end
  end

  // Entry payloads and latency countdown; a push overrides the countdown of its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid[i] && (cnt_q[i] != 4'd0)) cnt_q[i] <= cnt_q[i] - 4'd1;
    end
    if (push) begin
      is_wr_q[wr_ptr_q] <= wr;
      data_q[wr_ptr_q]  <= mem_q[word_idx];
      cnt_q[wr_ptr_q]   <= CntInit;
    end
  end

  // Byte-enabled memory write on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: directed vector table, randomized run against a
// queue-based reference model, and hand sequences on a long-latency instance.
module tb_sram_like_responder;

  localparam int unsigned Lat = 2;
  localparam int unsigned Qd  = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (LATENCY=2, QDEPTH=4).
  logic        reset, req, wr, stall_en;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  // Long-latency instance (LATENCY=8, QDEPTH=4).
  logic        b_reset, b_req, b_wr, b_stall_en;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_addr_ok, b_data_ok;
  logic [31:0] b_rdata;

  sram_like_responder #(.ADDR_W(10), .LATENCY(Lat), .QDEPTH(Qd)) u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall_en(stall_en), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.ADDR_W(10), .LATENCY(8), .QDEPTH(4)) u_dut8 (
    .clk(clk), .reset(b_reset), .req(b_req), .wr(b_wr), .size(b_size), .addr(b_addr),
    .wstrb(b_wstrb), .wdata(b_wdata), .stall_en(b_stall_en), .addr_ok(b_addr_ok),
    .data_ok(b_data_ok), .rdata(b_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rq, w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        st, aok, dok;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, input logic rq, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d, input logic st,
                     input logic aok, input logic dok, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.rq = rq; v.w = w; v.a = a; v.s = s; v.d = d; v.st = st;
    v.aok = aok; v.dok = dok; v.rd = rd;
    tbl.push_back(v);
  endtask

  // Reference model: pending responses carry the cycle they are due.
  typedef struct {
    int          due;
    logic        is_wr;
    logic [31:0] data;
  } resp_t;
  resp_t       mq[$];
  logic [31:0] mmem[16];
  int          cyc = 0;

  task automatic mstep();
    logic        e_aok, e_dok;
    logic [31:0] e_rd;
    int          idx;
    resp_t       r;
    @(negedge clk);
    e_aok = !reset && !stall_en && (mq.size() != Qd);
    e_dok = !reset && (mq.size() != 0) && (mq[0].due == cyc);
    e_rd  = (e_dok && !mq[0].is_wr) ? mq[0].data : 32'd0;
    chk($sformatf("rnd_addr_ok c%0d", cyc), {31'd0, addr_ok}, {31'd0, e_aok});
    chk($sformatf("rnd_data_ok c%0d", cyc), {31'd0, data_ok}, {31'd0, e_dok});
    chk($sformatf("rnd_rdata c%0d", cyc), rdata, e_rd);
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
      if (e_dok) void'(mq.pop_front());
      if (req && e_aok) begin
        idx     = int'(addr[5:2]);
        r.due   = cyc + Lat;
        r.is_wr = wr;
        r.data  = mmem[idx];
        mq.push_back(r);
        if (wr) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mmem[idx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bvals[5];
    logic        acc, e_aok, e_dok;
    int          n, rd_i, resp_i;
    logic [31:0] rv;

    reset = 1; req = 0; wr = 0; size = 2; addr = 0; wstrb = 0; wdata = 0; stall_en = 0;
    b_reset = 1; b_req = 0; b_wr = 0; b_size = 2; b_addr = 0; b_wstrb = 0; b_wdata = 0;
    b_stall_en = 0;

    //   rst rq w  addr          strb  wdata         st aok dok rdata
    add(1, 0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0);
    add(1, 1, 0, 32'h100,      4'h0, 32'h0,        0, 0, 0, 32'h0);
    // write-read
    add(0, 1, 1, 32'h100,      4'hF, 32'hDEADBEEF, 0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h100,      4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'hDEADBEEF);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    // byte strobes
    add(0, 1, 1, 32'h104,      4'hF, 32'h11223344, 0, 1, 0, 32'h0);
    add(0, 1, 1, 32'h104,      4'h5, 32'hAABBCCDD, 0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h106,      4'h0, 32'h0,        0, 1, 1, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h11BB33DD);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    // aliasing
    add(0, 1, 1, 32'h1000,     4'hF, 32'h00000055, 0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 1, 32'h00000055);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    // stall hook with two reads pending
    add(0, 1, 0, 32'h100,      4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h104,      4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h0,        4'h0, 32'h0,        1, 0, 1, 32'hDEADBEEF);
    add(0, 1, 0, 32'h0,        4'h0, 32'h0,        1, 0, 1, 32'h11BB33DD);
    add(0, 1, 0, 32'h0,        4'h0, 32'h0,        1, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    // reset kills a pending read before and at its due cycle
    add(0, 1, 0, 32'h100,      4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(1, 1, 0, 32'h100,      4'h0, 32'h0,        0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 1, 0, 32'h100,      4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);
    add(1, 0, 0, 32'h0,        4'h0, 32'h0,        0, 0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0, 32'h0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; req = tbl[i].rq; wr = tbl[i].w; addr = tbl[i].a;
      wstrb = tbl[i].s; wdata = tbl[i].d; stall_en = tbl[i].st;
      @(negedge clk);
      chk($sformatf("vec%0d addr_ok", i), {31'd0, addr_ok}, {31'd0, tbl[i].aok});
      chk($sformatf("vec%0d data_ok", i), {31'd0, data_ok}, {31'd0, tbl[i].dok});
      chk($sformatf("vec%0d rdata", i), rdata, tbl[i].rd);
      @(posedge clk);
      #1;
    end

    // Seed words 0..15 so every random read has a known value.
    mq.delete();
    for (int i = 0; i < 16; i++) begin
      reset = 0; stall_en = 0; req = 1; wr = 1; wstrb = 4'hF;
      wdata = $urandom(); addr = 32'(i) << 2;
      mstep();
    end
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      stall_en = ($urandom_range(0, 9) == 0);
      req      = ($urandom_range(0, 9) < 7);
      wr       = $urandom_range(0, 1) == 1;
      size     = 2'($urandom_range(0, 2));
      wstrb    = 4'($urandom_range(0, 15));
      wdata    = $urandom();
      rv       = $urandom();
      addr     = (rv & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      mstep();
    end
    reset = 0; req = 0; stall_en = 0;

    // Long-latency instance: preload five words.
    b_reset = 0;
    for (int i = 0; i < 5; i++) bvals[i] = $urandom();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      b_req = 1; b_wr = 1; b_wstrb = 4'hF; b_wdata = bvals[i]; b_addr = 32'(i) << 2;
      do begin
        @(negedge clk);
        acc = b_addr_ok;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 100);
    end
    chk("b_preload_bound", 32'(n < 100), 32'd1);
    b_req = 0;
    repeat (12) @(posedge clk);
    #1;

    // Full queue: reads held for 10 cycles, accepts at 0..3 and again at 9.
    rd_i = 0; resp_i = 0;
    for (int c = 0; c < 20; c++) begin
      b_req = (c < 10); b_wr = 0; b_addr = 32'(rd_i) << 2;
      @(negedge clk);
      e_aok = (c < 4) || (c >= 9);
      e_dok = (c >= 8 && c <= 11) || (c == 17);
      chk($sformatf("full c%0d addr_ok", c), {31'd0, b_addr_ok}, {31'd0, e_aok});
      chk($sformatf("full c%0d data_ok", c), {31'd0, b_data_ok}, {31'd0, e_dok});
      chk($sformatf("full c%0d rdata", c), b_rdata, e_dok ? bvals[resp_i] : 32'd0);
      if (e_dok) resp_i++;
      acc = b_req && b_addr_ok;
      @(posedge clk);
      #1;
      if (acc) rd_i++;
    end

    // Reset mid-flight: three reads accepted, one reset cycle, then silence.
    for (int c = 0; c < 16; c++) begin
      b_reset = (c == 3); b_req = (c <= 3); b_wr = 0; b_addr = 32'(c) << 2;
      @(negedge clk);
      chk($sformatf("rstmid c%0d addr_ok", c), {31'd0, b_addr_ok}, {31'd0, c != 3});
      chk($sformatf("rstmid c%0d data_ok", c), {31'd0, b_data_ok}, 32'd0);
      chk($sformatf("rstmid c%0d rdata", c), b_rdata, 32'd0);
      @(posedge clk);
      #1;
    end
    b_reset = 0; b_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Responder end of the pipeline's SRAM-like data bus. Accepts `req`/`addr_ok` handshakes from the EXE/MEM load-store path and answers every accepted request, in order, with a one-cycle `data_ok` pulse after a fixed latency. Backed by an internal word-addressed memory, it serves as the data-side memory model in core simulation and as the template for the later AXI bridge. Reads return the full aligned word; byte extraction and sign extension stay in the MEM stage.

## Interface
- `ADDR_W`, 10: memory depth is 2^ADDR_W 32-bit words.
- `LATENCY`, 2: cycles from acceptance to `data_ok`; legal range 1..15.
- `QDEPTH`, 4: maximum outstanding requests; power of two, at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  request valid.
- `wr`  in  1  1 = write, 0 = read.
- `size`  in  2  0 = byte, 1 = half, 2 = word. Informational only.
- `addr`  in  32  byte address.
- `wstrb`  in  4  byte enables for writes.
- `wdata`  in  32  write data.
- `stall_en`  in  1  test hook; forces `addr_ok` low.
- `addr_ok`  out  1  request accepted this cycle when `req & addr_ok`.
- `data_ok`  out  1  one-cycle response pulse; the master has no backpressure.
- `rdata`  out  32  read word; valid only while `data_ok` is high.

## Operation
- **Word index:** `addr[ADDR_W+1:2]`. `addr[1:0]` and the upper bits are ignored, so addresses alias.
- **addr_ok:** combinational, equal to `~reset & ~stall_en & (count != QDEPTH)`. There is no full-and-popping bypass: when the queue is full, `addr_ok` stays low even in a cycle where `data_ok` fires.
- **Write accept:** the memory is written on the accept edge. Bytes with `wstrb[i]` set take `wdata[8i+7:8i]`. `wstrb = 0` writes nothing but still produces a response.
- **Read accept:** the memory word is sampled at accept, so it reflects all previously accepted writes. The sampled word goes into the queue entry.
- **Queue:** a circular FIFO of QDEPTH entries. Each entry holds:
  - `is_wr`
  - `data[31:0]`
  - `cnt[3:0]`, loaded with LATENCY-1 at push
- **Countdown:** every valid entry with `cnt != 0` decrements each cycle.
- **Response:** `data_ok = head_valid & (head.cnt == 0)`. On `data_ok` the head pops.
- **rdata:** `head.data` for read entries. It is 0 for write responses and 0 whenever `data_ok` is low.
- **Pointers:** read and write pointers are log2(QDEPTH) bits and wrap naturally. `count` is log2(QDEPTH)+1 bits. A push and a pop in the same cycle leave `count` unchanged.
- **No flush input:** a pipeline flush (wb_ex) does not cancel outstanding requests. Every accepted request receives exactly one `data_ok`, and the master discards stale responses.
- **Reset:** empties the queue (pointers and count go to 0). Memory contents are not reset.

## Timing
- A request accepted in cycle T gets `data_ok` in cycle T+LATENCY at the earliest. It is later only if older responses are still queued, which cannot happen with fixed latency and in-order issue.
- Back-to-back accepts produce back-to-back `data_ok` pulses. Sustained throughput is 1 request per cycle when QDEPTH > LATENCY.
- When QDEPTH ≤ LATENCY, `addr_ok` drops after QDEPTH consecutive accepts and recovers the cycle after the first pop.
- Reset values, in and after any cycle with `reset` high:
  - `addr_ok` = 0
  - `data_ok` = 0
  - `rdata` = 0
  - queue empty
- Reset asserted mid-operation drops all pending responses. No `data_ok` appears in the cycle after reset deasserts.
- `stall_en` only gates new accepts. Pending responses still complete on schedule.

## Test plan
- **Write-read:** LATENCY=2. Accept a write of 0xDEADBEEF to 0x100 with `wstrb` 0xF in cycle 0, then a read of 0x100 in cycle 1. Required: `data_ok` in cycles 2 and 3, and `rdata` = 0xDEADBEEF in cycle 3.
- **Byte strobes:** 0x104 holds 0x11223344. Write `wdata` 0xAABBCCDD with `wstrb` 0b0101, then read 0x106. Required: `rdata` = 0x11BB33DD (full word, offset ignored).
- **Full queue:** QDEPTH=4, LATENCY=8, `req` held high on reads. Required: `addr_ok` high for exactly 4 cycles then low; the first `data_ok` comes 8 cycles after the first accept; `addr_ok` returns the cycle after that pop; 4 responses in order.
- **Stall hook:** `stall_en` high for 3 cycles while 2 reads are pending. Required: no accepts during the stall, and both `data_ok` pulses still arrive at T+LATENCY.
- **Reset mid-flight:** 3 reads accepted, then `reset` pulsed for 1 cycle before any response. Required: `data_ok` never fires for them, `addr_ok` is 0 during reset and 1 the following cycle.
- **Aliasing:** ADDR_W=10. Write 0x55 at 0x0000_1000, read 0x0000_0000. Required: `rdata` low byte = 0x55.
